id_ex_stage_reg: RTL and testbench
==================================

Name: id_ex_stage_reg

Overview:
- ID/EX pipeline boundary placed directly downstream of the main control decoder.
- Registers the decoder's four control bundles, load flag, register addresses, operand data and PC into the EX stage.
- Contains the load-use interlock. It stalls IF/ID and injects zero-control bubbles while a pending load destination is read by the instruction in ID.
- Honours a branch flush from EX.

Parameters:
- ID_W, 10, width of reg_rd_control bundle
- EX_W, 10, width of exec_control bundle
- MEM_W, 7, width of mem_control bundle
- WB_W, 2, width of wb_control bundle
- DATA_W, 32, operand/PC width
- LU_STALL, 1, bubble cycles required after a load (1..3)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- id_reg_rd_control  in  ID_W  {src1_mux,dest_mux,rd1,rd2,rd3,rd4,set_wr,set_upd,pc_mux,swp_mux}; rd1..rd4 are bits 7..4
- id_exec_control  in  EX_W  execute-stage controls
- id_mem_control  in  MEM_W  memory-stage controls
- id_wb_control  in  WB_W  {wr,reg_update}
- id_load_inst  in  1  ID instruction is a load
- id_rs1_addr, id_rs2_addr, id_rs3_addr, id_rs4_addr  in  4 each  source addresses gated by rd1..rd4
- id_rd_addr  in  4  destination address
- id_op1, id_op2, id_op3, id_pc  in  DATA_W each  operands and PC
- ex_flush  in  1  branch taken in EX; squash ID
- ex_exec_control, ex_mem_control, ex_wb_control  out  EX_W/MEM_W/WB_W  registered bundles
- ex_load_inst  out  1
- ex_rd_addr  out  4
- ex_op1, ex_op2, ex_op3, ex_pc  out  DATA_W each
- ex_valid  out  1  0 = bubble
- stall_if_id  out  1  combinational; hold PC and IF/ID register

Behaviour:
- One clock; reset is synchronous and active-high.
  - clock named clock, reset named reset.
  - On reset: every registered output is 0, pending counter is 0, pending_rd is 0, stall_if_id is 0.
- Latency: ID inputs appear on EX outputs 1 cycle later.
- Interlock state: pend_rd (4b) and cnt (2b).
  - State IDLE when cnt==0; state LOCK when cnt!=0.
- hazard = (cnt!=0) & any(rdN & (id_rsN_addr==pend_rd)), for N=1..4.
  - Disabled sources never match.
  - Register 15 is treated like any other register.
- stall_if_id = hazard & ~ex_flush.
- Priority per edge: reset > flush > hazard > normal.
  - Flush: insert bubble; cnt <= 0.
  - Hazard: insert bubble; cnt <= cnt-1; pend_rd held.
  - Normal: latch all ID inputs; ex_valid <= 1.
    - If id_load_inst & id_wb_control[1]: pend_rd <= id_rd_addr and cnt <= LU_STALL.
    - Otherwise cnt <= (cnt==0) ? 0 : cnt-1.
- Bubble definition:
  - ex_exec_control, ex_mem_control, ex_wb_control, ex_load_inst and ex_valid are all 0.
  - ex_rd_addr and the data outputs still load the ID values.
- An all-zero control word (decoder NULL) is latched as-is with ex_valid=1.
- A load whose next ID instruction is also a load to the same register: the second load stalls, then rearms pend_rd.
- Stall is bounded: at most LU_STALL consecutive stall cycles per load.
- Reset asserted during LOCK: cnt clears and stall drops in the same cycle as the reset edge.

Decomposition:
- Shared package pipe_ctrl_pkg:
  - bundle widths ID_W/EX_W/MEM_W/WB_W
  - bit-index constants RD1_BIT=7, RD2_BIT=6, RD3_BIT=5, RD4_BIT=4, WB_WR_BIT=1
  - bubble constants (all-zero bundles)
- One sub-module load_use_detect: pend_rd/cnt registers plus the comparator, producing hazard.

Test Plan:
- Reset held 2 cycles with random inputs -> all ex_* outputs 0 and stall_if_id=0 on the following cycle.
- ADD R1,R2,R3 then SUB R4,R5,R6 (no load), 1 instruction per cycle -> each appears on ex_* exactly 1 cycle later with ex_valid=1 and no stall.
- LDR R2,[R1] then ADD R3,R2,R4 (rd1, rs1=2) with LU_STALL=1:
  - stall_if_id=1 for 1 cycle; one bubble with ex_valid=0.
  - ADD appears the next cycle; stall returns to 0.
- Same sequence with LU_STALL=2 -> 2 stall cycles and 2 bubbles. Same sequence with ADD reading R7 -> 0 stalls.
- LDR R2 then STR reading R2 only via rd4 (rs4=2) -> stall. Same STR with rd4=0 -> no stall.
- LDR R2, then ADD R3,R2 asserted together with ex_flush -> stall_if_id=0, bubble latched, cnt=0. The next cycle's instruction reading R2 does not stall.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, bit positions and bubble constants for the ID/EX control bundles.
package pipe_ctrl_pkg;
    localparam int ID_W  = 10;
    localparam int EX_W  = 10;
    localparam int MEM_W = 7;
    localparam int WB_W  = 2;

    // rd1..rd4 enable the four source-register reads inside reg_rd_control
    localparam int RD1_BIT   = 7;
    localparam int RD2_BIT   = 6;
    localparam int RD3_BIT   = 5;
    localparam int RD4_BIT   = 4;
    localparam int WB_WR_BIT = 1;

    localparam logic [EX_W-1:0]  EX_BUBBLE  = '0;
    localparam logic [MEM_W-1:0] MEM_BUBBLE = '0;
    localparam logic [WB_W-1:0]  WB_BUBBLE  = '0;

    typedef enum logic {
        LU_IDLE = 1'b0,
        LU_LOCK = 1'b1
    } lu_state_e;

    function automatic logic src_match(input logic en, input logic [3:0] addr,
                                       input logic [3:0] pend);
        return en && (addr == pend);
    endfunction
endpackage

// File: rtl/id_ex_stage_reg_if.sv
// Decoder-side inputs and EX-side outputs of the ID/EX boundary; the stage uses the slave view.
interface id_ex_stage_reg_if #(
    parameter int ID_W   = pipe_ctrl_pkg::ID_W,
    parameter int EX_W   = pipe_ctrl_pkg::EX_W,
    parameter int MEM_W  = pipe_ctrl_pkg::MEM_W,
    parameter int WB_W   = pipe_ctrl_pkg::WB_W,
    parameter int DATA_W = 32
);
    logic [ID_W-1:0]   id_reg_rd_control;
    logic [EX_W-1:0]   id_exec_control;
    logic [MEM_W-1:0]  id_mem_control;
    logic [WB_W-1:0]   id_wb_control;
    logic              id_load_inst;
    logic [3:0]        id_rs1_addr;
    logic [3:0]        id_rs2_addr;
    logic [3:0]        id_rs3_addr;
    logic [3:0]        id_rs4_addr;
    logic [3:0]        id_rd_addr;
    logic [DATA_W-1:0] id_op1;
    logic [DATA_W-1:0] id_op2;
    logic [DATA_W-1:0] id_op3;
    logic [DATA_W-1:0] id_pc;
    logic              ex_flush;

    logic [EX_W-1:0]   ex_exec_control;
    logic [MEM_W-1:0]  ex_mem_control;
    logic [WB_W-1:0]   ex_wb_control;
    logic              ex_load_inst;
    logic [3:0]        ex_rd_addr;
    logic [DATA_W-1:0] ex_op1;
    logic [DATA_W-1:0] ex_op2;
    logic [DATA_W-1:0] ex_op3;
    logic [DATA_W-1:0] ex_pc;
    logic              ex_valid;
    logic              stall_if_id;

    modport master (
        output id_reg_rd_control, id_exec_control, id_mem_control, id_wb_control,
               id_load_inst, id_rs1_addr, id_rs2_addr, id_rs3_addr, id_rs4_addr,
               id_rd_addr, id_op1, id_op2, id_op3, id_pc, ex_flush,
        input  ex_exec_control, ex_mem_control, ex_wb_control, ex_load_inst,
               ex_rd_addr, ex_op1, ex_op2, ex_op3, ex_pc, ex_valid, stall_if_id
    );

    modport slave (
        input  id_reg_rd_control, id_exec_control, id_mem_control, id_wb_control,
               id_load_inst, id_rs1_addr, id_rs2_addr, id_rs3_addr, id_rs4_addr,
               id_rd_addr, id_op1, id_op2, id_op3, id_pc, ex_flush,
        output ex_exec_control, ex_mem_control, ex_wb_control, ex_load_inst,
               ex_rd_addr, ex_op1, ex_op2, ex_op3, ex_pc, ex_valid, stall_if_id
    );
endinterface

// File: rtl/id_ex_stage_reg_load_use_detect.sv
// Load-use interlock: remembers the destination of the last writing load and how many
// bubbles it still needs, and flags a hazard when an enabled source in ID reads it.
module load_use_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int LU_STALL = 1
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] i_rd_en,
    input  logic [3:0] i_rs1_addr,
    input  logic [3:0] i_rs2_addr,
    input  logic [3:0] i_rs3_addr,
    input  logic [3:0] i_rs4_addr,
    input  logic [3:0] i_rd_addr,
    input  logic       i_load_wr,
    input  logic       i_flush,
    output logic       o_hazard
);
    localparam logic [1:0] LU_CNT = 2'(LU_STALL);

    logic [3:0] r_pend_rd;
    logic [1:0] r_cnt;
    lu_state_e  w_state;
    logic [3:0] w_match;

    assign w_state    = (r_cnt == 2'd0) ? LU_IDLE : LU_LOCK;
    assign w_match[3] = src_match(i_rd_en[3], i_rs1_addr, r_pend_rd);
    assign w_match[2] = src_match(i_rd_en[2], i_rs2_addr, r_pend_rd);
    assign w_match[1] = src_match(i_rd_en[1], i_rs3_addr, r_pend_rd);
    assign w_match[0] = src_match(i_rd_en[0], i_rs4_addr, r_pend_rd);
    assign o_hazard   = (w_state == LU_LOCK) && (|w_match);

    // A stalled cycle still burns one bubble of the budget; a flush cancels the rest.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pend_rd <= 4'd0;
            r_cnt     <= 2'd0;
        end else if (i_flush) begin
            r_cnt <= 2'd0;
        end else if (o_hazard) begin
            r_cnt <= r_cnt - 2'd1;
        end else if (i_load_wr) begin
            r_pend_rd <= i_rd_addr;
            r_cnt     <= LU_CNT;
        end else if (w_state == LU_LOCK) begin
            r_cnt <= r_cnt - 2'd1;
        end
    end
endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use interlock: bubbles EX and holds IF/ID while a
// pending load result is still needed, and squashes the ID instruction on a branch flush.
module id_ex_stage_reg #(
    parameter int ID_W     = pipe_ctrl_pkg::ID_W,
    parameter int EX_W     = pipe_ctrl_pkg::EX_W,
    parameter int MEM_W    = pipe_ctrl_pkg::MEM_W,
    parameter int WB_W     = pipe_ctrl_pkg::WB_W,
    parameter int DATA_W   = 32,
    parameter int LU_STALL = 1
) (
    input  logic             clock,
    input  logic             reset,
    id_ex_stage_reg_if.slave ifc
);
    logic [EX_W-1:0]   r_exec;
    logic [MEM_W-1:0]  r_mem;
    logic [WB_W-1:0]   r_wb;
    logic              r_load;
    logic [3:0]        r_rd_addr;
    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [DATA_W-1:0] r_op3;
    logic [DATA_W-1:0] r_pc;
    logic              r_valid;

    logic [3:0]        w_rd_en;
    logic              w_load_wr;
    logic              w_hazard;
    logic              w_bubble;
    logic              w_unused_rdc;

    assign w_rd_en = {ifc.id_reg_rd_control[pipe_ctrl_pkg::RD1_BIT],
                      ifc.id_reg_rd_control[pipe_ctrl_pkg::RD2_BIT],
                      ifc.id_reg_rd_control[pipe_ctrl_pkg::RD3_BIT],
                      ifc.id_reg_rd_control[pipe_ctrl_pkg::RD4_BIT]};
    assign w_load_wr    = ifc.id_load_inst & ifc.id_wb_control[pipe_ctrl_pkg::WB_WR_BIT];
    assign w_bubble     = ifc.ex_flush | w_hazard;
    assign w_unused_rdc = ^ifc.id_reg_rd_control;

    load_use_detect #(
        .LU_STALL (LU_STALL)
    ) u_detect (
        .clock      (clock),
        .reset      (reset),
        .i_rd_en    (w_rd_en),
        .i_rs1_addr (ifc.id_rs1_addr),
        .i_rs2_addr (ifc.id_rs2_addr),
        .i_rs3_addr (ifc.id_rs3_addr),
        .i_rs4_addr (ifc.id_rs4_addr),
        .i_rd_addr  (ifc.id_rd_addr),
        .i_load_wr  (w_load_wr),
        .i_flush    (ifc.ex_flush),
        .o_hazard   (w_hazard)
    );

    // Address and data always follow ID; only the control side is zeroed for a bubble.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_exec    <= '0;
            r_mem     <= '0;
            r_wb      <= '0;
            r_load    <= 1'b0;
            r_rd_addr <= 4'd0;
            r_op1     <= '0;
            r_op2     <= '0;
            r_op3     <= '0;
            r_pc      <= '0;
            r_valid   <= 1'b0;
        end else begin
            r_rd_addr <= ifc.id_rd_addr;
            r_op1     <= ifc.id_op1;
            r_op2     <= ifc.id_op2;
            r_op3     <= ifc.id_op3;
            r_pc      <= ifc.id_pc;
            if (w_bubble) begin
                r_exec  <= EX_W'(pipe_ctrl_pkg::EX_BUBBLE);
                r_mem   <= MEM_W'(pipe_ctrl_pkg::MEM_BUBBLE);
                r_wb    <= WB_W'(pipe_ctrl_pkg::WB_BUBBLE);
                r_load  <= 1'b0;
                r_valid <= 1'b0;
            end else begin
                r_exec  <= ifc.id_exec_control;
                r_mem   <= ifc.id_mem_control;
                r_wb    <= ifc.id_wb_control;
                r_load  <= ifc.id_load_inst;
                r_valid <= 1'b1;
            end
        end
    end

    assign ifc.ex_exec_control = r_exec;
    assign ifc.ex_mem_control  = r_mem;
    assign ifc.ex_wb_control   = r_wb;
    assign ifc.ex_load_inst    = r_load;
    assign ifc.ex_rd_addr      = r_rd_addr;
    assign ifc.ex_op1          = r_op1;
    assign ifc.ex_op2          = r_op2;
    assign ifc.ex_op3          = r_op3;
    assign ifc.ex_pc           = r_pc;
    assign ifc.ex_valid        = r_valid;
    assign ifc.stall_if_id     = w_hazard & ~ifc.ex_flush;
endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Drives two ID/EX stages (one-bubble and two-bubble load-use) with the same instruction
// stream and checks them against a behavioural model of the pipeline boundary.
module tb_id_ex_stage_reg;
    import pipe_ctrl_pkg::*;

    localparam int DW    = 32;
    localparam int BUS_W = EX_W + MEM_W + WB_W + 1 + 4 + 4 * DW + 1;
    localparam int K_NOP = 0, K_ALU = 1, K_LOAD = 2, K_STORE = 3;

    typedef struct {
        int         kind;
        logic [3:0] rd;
        logic [3:0] a;
        logic [3:0] b;
        logic       fl;
        logic       rs;
    } inst_t;

    logic clock;
    logic reset;
    initial clock = 1'b0;
    always #5 clock = ~clock;

    id_ex_stage_reg_if ifA ();
    id_ex_stage_reg_if ifB ();

    id_ex_stage_reg #(.LU_STALL(1)) u_dut1 (.clock(clock), .reset(reset), .ifc(ifA.slave));
    id_ex_stage_reg #(.LU_STALL(2)) u_dut2 (.clock(clock), .reset(reset), .ifc(ifB.slave));

    wire [BUS_W-1:0] obsBus [2];
    wire             obsStall [2];
    assign obsBus[0] = {ifA.ex_exec_control, ifA.ex_mem_control, ifA.ex_wb_control, ifA.ex_load_inst,
                        ifA.ex_rd_addr, ifA.ex_op1, ifA.ex_op2, ifA.ex_op3, ifA.ex_pc, ifA.ex_valid};
    assign obsBus[1] = {ifB.ex_exec_control, ifB.ex_mem_control, ifB.ex_wb_control, ifB.ex_load_inst,
                        ifB.ex_rd_addr, ifB.ex_op1, ifB.ex_op2, ifB.ex_op3, ifB.ex_pc, ifB.ex_valid};
    assign obsStall[0] = ifA.stall_if_id;
    assign obsStall[1] = ifB.stall_if_id;

    logic [ID_W-1:0]  idRdc;
    logic [EX_W-1:0]  idExec;
    logic [MEM_W-1:0] idMem;
    logic [WB_W-1:0]  idWb;
    logic             idLoad;
    logic [3:0]       idRs [4];
    logic [3:0]       idRd;
    logic [DW-1:0]    idOp [3];
    logic [DW-1:0]    idPc;
    logic             exFlush;
    logic             rstReq;

    int              lu [2] = '{1, 2};
    logic [3:0]      pendRd [2];
    int              left [2];
    logic [BUS_W-1:0] expBus [2];
    inst_t           prog [$];
    int              total;
    int              bad;

    function automatic logic modelStall(int k);
        logic hit;
        hit = 1'b0;
        for (int n = 0; n < 4; n++)
            if (idRdc[7-n] && (idRs[n] == pendRd[k])) hit = 1'b1;
        return (left[k] > 0) && hit && !exFlush;
    endfunction

    function automatic logic [3:0] pickReg();
        int r;
        r = $urandom_range(0, 4);
        return (r == 4) ? 4'd15 : 4'(r);
    endfunction

    task automatic randomData();
        idRdc   = ID_W'($urandom);
        idExec  = EX_W'($urandom);
        idMem   = MEM_W'($urandom);
        idWb    = WB_W'($urandom);
        idLoad  = 1'b0;
        idRd    = 4'($urandom);
        for (int i = 0; i < 4; i++) idRs[i] = 4'($urandom);
        for (int i = 0; i < 3; i++) idOp[i] = $urandom;
        idPc    = $urandom;
        exFlush = 1'b0;
        rstReq  = 1'b0;
    endtask

    task automatic setInst(input inst_t in);
        randomData();
        case (in.kind)
            K_NOP: begin
                idRdc = '0; idExec = '0; idMem = '0; idWb = '0;
            end
            K_ALU: begin
                idRdc = {2'($urandom), 4'b1100, 4'($urandom)};
                idRs[0] = in.a; idRs[1] = in.b; idRd = in.rd; idWb = 2'b11;
            end
            K_LOAD: begin
                idRdc = {2'($urandom), 4'b1000, 4'($urandom)};
                idRs[0] = in.a; idRd = in.rd; idLoad = 1'b1; idWb = 2'b10;
            end
            default: begin
                idRdc = {2'($urandom), 3'b000, in.b[0], 4'($urandom)};
                for (int i = 0; i < 4; i++) idRs[i] = in.a;
                idWb = 2'b00;
            end
        endcase
        exFlush = in.fl;
        rstReq  = in.rs;
    endtask

    task automatic addInst(int kind, int rd, int a, int b, bit fl = 1'b0, bit rs = 1'b0);
        inst_t t;
        t.kind = kind; t.rd = 4'(rd); t.a = 4'(a); t.b = 4'(b); t.fl = fl; t.rs = rs;
        prog.push_back(t);
    endtask

    task automatic applyStimulus();
        @(negedge clock);
        reset = rstReq;
        ifA.id_reg_rd_control = idRdc;  ifB.id_reg_rd_control = idRdc;
        ifA.id_exec_control   = idExec; ifB.id_exec_control   = idExec;
        ifA.id_mem_control    = idMem;  ifB.id_mem_control    = idMem;
        ifA.id_wb_control     = idWb;   ifB.id_wb_control     = idWb;
        ifA.id_load_inst      = idLoad; ifB.id_load_inst      = idLoad;
        ifA.id_rs1_addr = idRs[0]; ifB.id_rs1_addr = idRs[0];
        ifA.id_rs2_addr = idRs[1]; ifB.id_rs2_addr = idRs[1];
        ifA.id_rs3_addr = idRs[2]; ifB.id_rs3_addr = idRs[2];
        ifA.id_rs4_addr = idRs[3]; ifB.id_rs4_addr = idRs[3];
        ifA.id_rd_addr  = idRd;    ifB.id_rd_addr  = idRd;
        ifA.id_op1 = idOp[0]; ifB.id_op1 = idOp[0];
        ifA.id_op2 = idOp[1]; ifB.id_op2 = idOp[1];
        ifA.id_op3 = idOp[2]; ifB.id_op3 = idOp[2];
        ifA.id_pc  = idPc;    ifB.id_pc  = idPc;
        ifA.ex_flush = exFlush; ifB.ex_flush = exFlush;
        #1;
    endtask

    // Advance the reference model by one edge, then let the DUTs take the same edge.
    task automatic tick();
        for (int k = 0; k < 2; k++) begin
            logic hz;
            hz = (left[k] > 0) && modelStall(k) || (exFlush && 1'b0);
            if (exFlush) begin
                exFlush = 1'b0;
                hz = modelStall(k);
                exFlush = 1'b1;
            end
            if (reset) begin
                expBus[k] = '0; pendRd[k] = 4'd0; left[k] = 0;
            end else if (exFlush || hz) begin
                expBus[k] = {{(EX_W + MEM_W + WB_W + 1){1'b0}}, idRd, idOp[0], idOp[1], idOp[2], idPc, 1'b0};
                left[k] = exFlush ? 0 : left[k] - 1;
            end else begin
                expBus[k] = {idExec, idMem, idWb, idLoad, idRd, idOp[0], idOp[1], idOp[2], idPc, 1'b1};
                if (idLoad && idWb[1]) begin
                    pendRd[k] = idRd; left[k] = lu[k];
                end else if (left[k] > 0) begin
                    left[k]--;
                end
            end
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 2; c++) begin
            randomData();
            idLoad = 1'($urandom); exFlush = 1'($urandom); rstReq = 1'b1;
            applyStimulus();
            tick();
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (obsBus[k] !== expBus[k]) begin
                bad++; $display("FAIL reset_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
            end
            total++;
            if (obsStall[k] !== 1'b0) begin
                bad++; $display("FAIL reset_stall dut%0d got=%b want=0", k, obsStall[k]);
            end
        end
    endtask

    task automatic test_no_load();
        prog.delete();
        addInst(K_ALU, 1, 2, 3); addInst(K_ALU, 4, 5, 6); addInst(K_NOP, 0, 0, 0);
        foreach (prog[i]) begin
            setInst(prog[i]);
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== 1'b0) begin
                    bad++; $display("FAIL noload_stall dut%0d got=%b want=0", k, obsStall[k]);
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k] || obsBus[k][0] !== 1'b1) begin
                    bad++; $display("FAIL noload_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
                end
            end
        end
    endtask

    task automatic test_load_use();
        int idx;
        int lastIdx;
        int stalls [2];
        int bubbles [2];
        logic hold;
        idx = 0; lastIdx = -1; stalls = '{0, 0}; bubbles = '{0, 0};
        prog.delete();
        addInst(K_NOP, 0, 0, 0);   addInst(K_LOAD, 2, 1, 0); addInst(K_ALU, 3, 2, 4);
        addInst(K_NOP, 0, 0, 0);   addInst(K_NOP, 0, 0, 0);
        addInst(K_LOAD, 2, 1, 0);  addInst(K_ALU, 3, 7, 4);
        addInst(K_NOP, 0, 0, 0);   addInst(K_NOP, 0, 0, 0);
        addInst(K_LOAD, 2, 1, 0);  addInst(K_STORE, 0, 2, 1);
        addInst(K_NOP, 0, 0, 0);   addInst(K_NOP, 0, 0, 0);
        addInst(K_LOAD, 2, 1, 0);  addInst(K_STORE, 0, 2, 0);
        addInst(K_NOP, 0, 0, 0);   addInst(K_NOP, 0, 0, 0);
        for (int cyc = 0; cyc < 60 && idx < prog.size(); cyc++) begin
            if (idx != lastIdx) setInst(prog[idx]);
            lastIdx = idx;
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== modelStall(k)) begin
                    bad++; $display("FAIL lu_stall dut%0d got=%b want=%b", k, obsStall[k], modelStall(k));
                end
                stalls[k] += int'(obsStall[k] === 1'b1);
            end
            hold = modelStall(0) || modelStall(1);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k]) begin
                    bad++; $display("FAIL lu_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
                end
                bubbles[k] += int'(obsBus[k][0] === 1'b0);
            end
            if (!hold) idx++;
        end
        total++;
        if (idx != prog.size()) begin
            bad++; $display("FAIL lu_timeout reached=%0d want=%0d", idx, prog.size());
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (stalls[k] != 2 * lu[k] || bubbles[k] != 2 * lu[k]) begin
                bad++; $display("FAIL lu_count dut%0d stalls=%0d bubbles=%0d want=%0d", k, stalls[k], bubbles[k], 2 * lu[k]);
            end
        end
    endtask

    task automatic test_flush();
        int stalls [2];
        int bubbles [2];
        stalls = '{0, 0}; bubbles = '{0, 0};
        prog.delete();
        addInst(K_NOP, 0, 0, 0); addInst(K_LOAD, 2, 1, 0); addInst(K_ALU, 3, 2, 4, 1'b1);
        addInst(K_ALU, 5, 2, 6); addInst(K_NOP, 0, 0, 0);
        foreach (prog[i]) begin
            setInst(prog[i]);
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== modelStall(k)) begin
                    bad++; $display("FAIL flush_stall dut%0d got=%b want=%b", k, obsStall[k], modelStall(k));
                end
                stalls[k] += int'(obsStall[k] === 1'b1);
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k]) begin
                    bad++; $display("FAIL flush_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
                end
                bubbles[k] += int'(obsBus[k][0] === 1'b0);
            end
        end
        for (int k = 0; k < 2; k++) begin
            total++;
            if (stalls[k] != 0 || bubbles[k] != 1) begin
                bad++; $display("FAIL flush_count dut%0d stalls=%0d bubbles=%0d want=0/1", k, stalls[k], bubbles[k]);
            end
        end
    endtask

    task automatic test_load_load();
        int idx;
        int lastIdx;
        logic hold;
        idx = 0; lastIdx = -1;
        prog.delete();
        addInst(K_NOP, 0, 0, 0); addInst(K_LOAD, 2, 1, 0); addInst(K_LOAD, 2, 2, 0);
        addInst(K_ALU, 3, 2, 4); addInst(K_NOP, 0, 0, 0); addInst(K_NOP, 0, 0, 0);
        for (int cyc = 0; cyc < 30 && idx < prog.size(); cyc++) begin
            if (idx != lastIdx) setInst(prog[idx]);
            lastIdx = idx;
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== modelStall(k)) begin
                    bad++; $display("FAIL ldld_stall dut%0d got=%b want=%b", k, obsStall[k], modelStall(k));
                end
            end
            hold = modelStall(0) || modelStall(1);
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k]) begin
                    bad++; $display("FAIL ldld_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
                end
            end
            if (!hold) idx++;
        end
        total++;
        if (idx != prog.size()) begin
            bad++; $display("FAIL ldld_timeout reached=%0d want=%0d", idx, prog.size());
        end
    endtask

    task automatic test_reset_lock();
        logic curRst;
        prog.delete();
        addInst(K_NOP, 0, 0, 0); addInst(K_LOAD, 2, 1, 0); addInst(K_ALU, 3, 2, 4, 1'b0, 1'b1);
        addInst(K_ALU, 3, 2, 4); addInst(K_NOP, 0, 0, 0);
        foreach (prog[i]) begin
            setInst(prog[i]);
            curRst = prog[i].rs;
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== modelStall(k)) begin
                    bad++; $display("FAIL rstlock_stall dut%0d got=%b want=%b", k, obsStall[k], modelStall(k));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k]) begin
                    bad++; $display("FAIL rstlock_bus dut%0d got=%h want=%h", k, obsBus[k], expBus[k]);
                end
                if (curRst) begin
                    total++;
                    if (obsStall[k] !== 1'b0) begin
                        bad++; $display("FAIL rstlock_drop dut%0d got=%b want=0", k, obsStall[k]);
                    end
                end
            end
        end
    endtask

    task automatic test_random();
        inst_t t;
        for (int cyc = 0; cyc < 400; cyc++) begin
            t.kind = $urandom_range(0, 3);
            t.rd = pickReg(); t.a = pickReg(); t.b = pickReg();
            t.fl = ($urandom_range(0, 7) == 0);
            t.rs = ($urandom_range(0, 49) == 0);
            if (t.kind == K_STORE) t.b = 4'($urandom_range(0, 1));
            setInst(t);
            if (t.kind == K_ALU && $urandom_range(0, 1) == 1) begin
                idRdc[7:4] = 4'($urandom);
                idRs[2] = pickReg(); idRs[3] = pickReg();
            end
            applyStimulus();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsStall[k] !== modelStall(k)) begin
                    bad++; $display("FAIL rand_stall dut%0d cyc=%0d got=%b want=%b", k, cyc, obsStall[k], modelStall(k));
                end
            end
            tick();
            for (int k = 0; k < 2; k++) begin
                total++;
                if (obsBus[k] !== expBus[k]) begin
                    bad++; $display("FAIL rand_bus dut%0d cyc=%0d got=%h want=%h", k, cyc, obsBus[k], expBus[k]);
                end
            end
        end
    endtask

    initial begin
        total  = 0;
        bad    = 0;
        reset  = 1'b1;
        rstReq = 1'b1;
        pendRd = '{4'd0, 4'd0};
        left   = '{0, 0};
        expBus = '{'0, '0};
        randomData();
        rstReq = 1'b1;
        test_reset();
        test_no_load();
        test_load_use();
        test_flush();
        test_load_load();
        test_reset_lock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
